// File: rtl/laser_collision_if.sv
// Game-side bundle for the laser/collision controller: player inputs, invader
// positions and hold-counter handshake in, shot position, hit flags and score out.
interface laser_collision_if #(
    parameter int unsigned SCORE_W = 8
);
    logic               Start;
    logic               fire;
    logic [1:0]         lane;
    logic [7:0]         inv0_x;
    logic [7:0]         inv1_x;
    logic [7:0]         inv2_x;
    logic               eraseOn;
    logic [7:0]         laser_x;
    logic               laser_on;
    logic [1:0]         laser_lane;
    logic [2:0]         collisionFlag;
    logic               redOn;
    logic [SCORE_W-1:0] score;

    modport master (
        output Start, fire, lane, inv0_x, inv1_x, inv2_x, eraseOn,
        input  laser_x, laser_on, laser_lane, collisionFlag, redOn, score
    );

    modport slave (
        input  Start, fire, lane, inv0_x, inv1_x, inv2_x, eraseOn,
        output laser_x, laser_on, laser_lane, collisionFlag, redOn, score
    );
endinterface

// File: rtl/laser_collision_ctrl.sv
// Player laser shot controller and lane hit detector with score keeping.
// Optional LASER_FAST_BONUS_EN: hits on the lane-2 (fast) invader score 2.
module laser_collision_ctrl #(
    parameter int unsigned X_START  = 40,
    parameter int unsigned X_MAX    = 240,
    parameter int unsigned X_STEP   = 2,
    parameter int unsigned STEP_DIV = 250000,
    parameter int unsigned HIT_WIN  = 4,
    parameter int unsigned SCORE_W  = 8
) (
    input  logic              clk,
    input  logic              resetn,
    laser_collision_if.slave  bus
);

    localparam int unsigned XW    = 8;
    localparam int unsigned CW    = XW + 1;
    localparam int unsigned DIV_W = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
    localparam int unsigned SW1   = SCORE_W + 1;
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

    typedef enum logic [1:0] {IDLE, FLY, HIT, CLEAR} state_t;

    state_t             state_q, state_d;
    logic               fire_d;
    logic [XW-1:0]      laser_x_q, laser_x_d;
    logic               laser_on_q, laser_on_d;
    logic [1:0]         lane_q, lane_d;
    logic [2:0]         flag_q, flag_d;
    logic               red_q, red_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [DIV_W-1:0]   div_q, div_d;

    logic               fire_edge;
    logic [1:0]         lane_clamp;
    logic [XW-1:0]      inv_sel;
    logic               hit_c;
    logic               tick_c;
    logic               miss_c;
    logic [2:0]         onehot;
    logic [1:0]         inc;
    logic [SW1-1:0]     score_sum;
    logic [SCORE_W-1:0] score_next;

    // Datapath helpers: edge detect, lane clamp, lane-selected invader compare
    always_comb begin
        fire_edge  = bus.fire & ~fire_d;
        lane_clamp = (bus.lane == 2'd3) ? 2'd2 : bus.lane;
        case (lane_q)
            2'd0:    inv_sel = bus.inv0_x;
            2'd1:    inv_sel = bus.inv1_x;
            default: inv_sel = bus.inv2_x;
        endcase
        case (lane_q)
            2'd0:    onehot = 3'b001;
            2'd1:    onehot = 3'b010;
            default: onehot = 3'b100;
        endcase
        hit_c  = ({1'b0, laser_x_q} + CW'(HIT_WIN)) >= {1'b0, inv_sel};
        miss_c = ({1'b0, laser_x_q} + CW'(X_STEP)) >= CW'(X_MAX);
        tick_c = (div_q == DIV_W'(STEP_DIV - 1));
`ifdef LASER_FAST_BONUS_EN
        inc = (lane_q == 2'd2) ? 2'd2 : 2'd1;
`else
        inc = 2'd1;
`endif
        score_sum  = {1'b0, score_q} + SW1'(inc);
        score_next = (score_sum > {1'b0, SCORE_MAX}) ? SCORE_MAX : score_sum[SCORE_W-1:0];
    end

    // Next-state and next-output logic
    always_comb begin
        state_d    = state_q;
        laser_x_d  = laser_x_q;
        laser_on_d = laser_on_q;
        lane_d     = lane_q;
        flag_d     = flag_q;
        red_d      = red_q;
        score_d    = score_q;
        div_d      = div_q;
        case (state_q)
            IDLE: begin
                laser_on_d = 1'b0;
                flag_d     = 3'b000;
                red_d      = 1'b0;
                if (bus.Start && fire_edge) begin
                    state_d    = FLY;
                    laser_x_d  = XW'(X_START);
                    laser_on_d = 1'b1;
                    lane_d     = lane_clamp;
                    div_d      = '0;
                end
            end
            FLY: begin
                if (!bus.Start) begin
                    state_d    = IDLE;
                    laser_on_d = 1'b0;
                end else if (hit_c) begin
                    state_d    = HIT;
                    laser_on_d = 1'b0;
                    flag_d     = onehot;
                    red_d      = 1'b1;
                    score_d    = score_next;
                end else if (tick_c) begin
                    div_d = '0;
                    if (miss_c) begin
                        state_d    = IDLE;
                        laser_on_d = 1'b0;
                    end else begin
                        laser_x_d = laser_x_q + XW'(X_STEP);
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            HIT: begin
                // Start is ignored so the hold-counter handshake always completes
                laser_on_d = 1'b0;
                flag_d     = onehot;
                red_d      = 1'b1;
                if (bus.eraseOn) begin
                    state_d = CLEAR;
                    flag_d  = 3'b000;
                    red_d   = 1'b0;
                end
            end
            CLEAR: begin
                flag_d = 3'b000;
                red_d  = 1'b0;
                if (!bus.eraseOn) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            fire_d     <= 1'b0;
            laser_x_q  <= '0;
            laser_on_q <= 1'b0;
            lane_q     <= 2'd0;
            flag_q     <= 3'b000;
            red_q      <= 1'b0;
            score_q    <= '0;
            div_q      <= '0;
        end else begin
            state_q    <= state_d;
            fire_d     <= bus.fire;
            laser_x_q  <= laser_x_d;
            laser_on_q <= laser_on_d;
            lane_q     <= lane_d;
            flag_q     <= flag_d;
            red_q      <= red_d;
            score_q    <= score_d;
            div_q      <= div_d;
        end
    end

    assign bus.laser_x       = laser_x_q;
    assign bus.laser_on      = laser_on_q;
    assign bus.laser_lane    = lane_q;
    assign bus.collisionFlag = flag_q;
    assign bus.redOn         = red_q;
    assign bus.score         = score_q;

endmodule
